regfile_sb: RTL and testbench

Parametrised successor to the 16×16 processor register file. It provides two registered read ports and one write port, with write-to-read bypass, an optional hard-wired zero register, synchronous clear, and a per-register scoreboard. The scoreboard tracks destinations reserved by the issue stage but not yet written back. It sits between decode/issue (read and reserve) and writeback (load) in the RISC datapath.

---
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: two-read / one-write register file. Reads are registered and
// see same-edge writes (write-first). Register 0 can optionally be hard-wired
// to zero. A per-register busy scoreboard tracks destinations that have been
// reserved but not yet written back, and a population counter of busy bits
// is kept alongside it.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] Caddr,
  input  logic [DATA_W-1:0] C,
  input  logic              load,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              A_busy,
  output logic              B_busy,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  load_hit;
  logic [DEPTH-1:0]  rsv_hit;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              a_busy_q, b_busy_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              load_ok;
  logic              rsv_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  // Writes and reservations aimed at a hard-wired zero register are dropped.
  assign load_ok = load && !(HAS_ZERO && (Caddr == '0));
  assign rsv_ok  = rsv  && !(HAS_ZERO && (rsv_addr == '0));

  // Per-register next busy bit: a reservation wins over a same-edge writeback.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign load_hit[gi] = load_ok && (Caddr == ADDR_W'(gi));
      assign rsv_hit[gi]  = rsv_ok && (rsv_addr == ADDR_W'(gi));
      assign busy_d[gi]   = rsv_hit[gi] | (busy_q[gi] & ~load_hit[gi]);
    end
  endgenerate

  // Count delta: a writeback only releases a busy bit that is not being
  // re-reserved on the same edge; a reservation only counts if the bit was idle.
  always_comb begin
    cnt_inc = rsv_ok && !busy_q[rsv_addr];
    cnt_dec = load_ok && busy_q[Caddr] && !(rsv_ok && (rsv_addr == Caddr));
    cnt_d   = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  // Read data next-state: zero register, then write-first bypass, then storage.
  always_comb begin
    if (HAS_ZERO && (Aaddr == '0))
      a_d = '0;
    else if (load_ok && (Caddr == Aaddr))
      a_d = C;
    else
      a_d = mem_q[Aaddr];
    if (HAS_ZERO && (Baddr == '0))
      b_d = '0;
    else if (load_ok && (Caddr == Baddr))
      b_d = C;
    else
      b_d = mem_q[Baddr];
  end

  // Register storage; clear wipes every entry.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (load_ok) begin
      mem_q[Caddr] <= C;
    end
  end

  // Scoreboard bits and their population count.
  always_ff @(posedge clock) begin
    if (clear) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Registered read ports; they hold while rd_en is low.
  always_ff @(posedge clock) begin
    if (clear) begin
      a_q      <= '0;
      b_q      <= '0;
      a_busy_q <= 1'b0;
      b_busy_q <= 1'b0;
    end else if (rd_en) begin
      a_q      <= a_d;
      b_q      <= b_d;
      a_busy_q <= busy_d[Aaddr];
      b_busy_q <= busy_d[Baddr];
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign A_busy     = a_busy_q;
  assign B_busy     = b_busy_q;
  assign busy_count = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb. Two instances share the stimulus: dut0 has
// ZERO_REG=0, dut1 has ZERO_REG=1. Each step pushes its expected outputs to a
// queue before the clock edge; after the edge the entry is popped and compared.
module tb_regfile_sb;

  logic        clk;
  logic        clear;
  logic [3:0]  aaddr, baddr, caddr, rsv_addr;
  logic        rd_en, load, rsv;
  logic [15:0] c;
  logic [15:0] a0, b0, a1, b1;
  logic        ab0, bb0, ab1, bb1;
  logic [4:0]  cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        z;
    logic [15:0] a;
    logic [15:0] b;
    logic        ab;
    logic        bb;
    logic [4:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
    .clock(clk), .clear(clear), .Aaddr(aaddr), .Baddr(baddr), .rd_en(rd_en),
    .Caddr(caddr), .C(c), .load(load), .rsv(rsv), .rsv_addr(rsv_addr),
    .A(a0), .B(b0), .A_busy(ab0), .B_busy(bb0), .busy_count(cnt0)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut1 (
    .clock(clk), .clear(clear), .Aaddr(aaddr), .Baddr(baddr), .rd_en(rd_en),
    .Caddr(caddr), .C(c), .load(load), .rsv(rsv), .rsv_addr(rsv_addr),
    .A(a1), .B(b1), .A_busy(ab1), .B_busy(bb1), .busy_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  task automatic drive(input logic clr, input logic rd, input logic [3:0] aa,
                       input logic [3:0] ba, input logic ld, input logic [3:0] ca,
                       input logic [15:0] cd, input logic rs, input logic [3:0] ra);
    clear    = clr;
    rd_en    = rd;
    aaddr    = aa;
    baddr    = ba;
    load     = ld;
    caddr    = ca;
    c        = cd;
    rsv      = rs;
    rsv_addr = ra;
  endtask

  // Push expectation, clock once, pop and compare against the selected DUT.
  task automatic step(input string tag, input logic z, input logic [15:0] ea,
                      input logic [15:0] eb, input logic eab, input logic ebb,
                      input logic [4:0] ecnt);
    exp_t e;
    exp_t got;
    e = '{z: z, a: ea, b: eb, ab: eab, bb: ebb, cnt: ecnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = exp_q.pop_front();
      if (got.z) begin
        chk(tag, "A", a1, got.a);
        chk(tag, "B", b1, got.b);
        chk(tag, "A_busy", {15'd0, ab1}, {15'd0, got.ab});
        chk(tag, "B_busy", {15'd0, bb1}, {15'd0, got.bb});
        chk(tag, "busy_count", {11'd0, cnt1}, {11'd0, got.cnt});
      end else begin
        chk(tag, "A", a0, got.a);
        chk(tag, "B", b0, got.b);
        chk(tag, "A_busy", {15'd0, ab0}, {15'd0, got.ab});
        chk(tag, "B_busy", {15'd0, bb0}, {15'd0, got.bb});
        chk(tag, "busy_count", {11'd0, cnt0}, {11'd0, got.cnt});
      end
    end
    $display("step %-8s z=%0b A=%h B=%h Ab=%0b Bb=%0b cnt=%0d", tag, got.z,
             got.z ? a1 : a0, got.z ? b1 : b0, got.z ? ab1 : ab0,
             got.z ? bb1 : bb0, got.z ? cnt1 : cnt0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    step("rst", 0, 16'h0, 16'h0, 0, 0, 5'd0);

    // Clear discards stored data and reservations, and overrides load/rsv/rd_en.
    drive(0, 1, 5, 6, 1, 5, 16'hFFFF, 1, 6);
    step("pre_clr", 0, 16'hFFFF, 16'h0, 0, 1, 5'd1);
    drive(1, 1, 5, 6, 1, 5, 16'hFFFF, 1, 6);
    step("clr", 0, 16'h0, 16'h0, 0, 0, 5'd0);
    drive(0, 1, 5, 6, 0, 0, 16'h0, 0, 0);
    step("clr_rd", 0, 16'h0, 16'h0, 0, 0, 5'd0);

    // Write then read through storage.
    drive(0, 0, 2, 3, 1, 2, 16'hAAAE, 0, 0);
    step("wr2", 0, 16'h0, 16'h0, 0, 0, 5'd0);
    drive(0, 1, 2, 3, 0, 0, 16'h0, 0, 0);
    step("rd2", 0, 16'hAAAE, 16'h0, 0, 0, 5'd0);

    // Same-edge bypass on both ports.
    drive(0, 1, 15, 15, 1, 15, 16'hF0E3, 0, 0);
    step("byp", 0, 16'hF0E3, 16'hF0E3, 0, 0, 5'd0);

    // Scoreboard behaviour.
    drive(0, 1, 4, 15, 0, 0, 16'h0, 1, 4);
    step("rsv4", 0, 16'h0, 16'hF0E3, 1, 0, 5'd1);
    drive(0, 1, 4, 15, 1, 4, 16'h1234, 0, 0);
    step("ld4", 0, 16'h1234, 16'hF0E3, 0, 0, 5'd0);
    drive(0, 1, 7, 4, 1, 7, 16'hBEEF, 1, 7);
    step("ldrsv7", 0, 16'hBEEF, 16'h1234, 1, 0, 5'd1);
    drive(0, 1, 7, 9, 1, 7, 16'hCAFE, 1, 9);
    step("net", 0, 16'hCAFE, 16'h0, 0, 1, 5'd1);
    drive(0, 1, 3, 9, 1, 3, 16'h0003, 0, 0);
    step("ld_nb", 0, 16'h0003, 16'h0, 0, 1, 5'd1);

    // Fill the scoreboard: count reaches DEPTH without wrapping.
    drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    step("clr2", 0, 16'h0, 16'h0, 0, 0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'(i), 0, 0, 0, 16'h0, 1, 4'(i));
      step("fill", 0, 16'h0, 16'h0, 1, 1, 5'(i + 1));
    end
    drive(0, 1, 3, 15, 0, 0, 16'h0, 1, 3);
    step("rersv3", 0, 16'h0, 16'h0, 1, 1, 5'd16);

    // Hard-wired zero register instance.
    drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    step("z_clr", 1, 16'h0, 16'h0, 0, 0, 5'd0);
    drive(0, 1, 0, 0, 1, 0, 16'h5555, 1, 0);
    step("z_r0", 1, 16'h0, 16'h0, 0, 0, 5'd0);
    drive(0, 1, 0, 0, 0, 0, 16'h0, 0, 0);
    step("z_r0b", 1, 16'h0, 16'h0, 0, 0, 5'd0);
    drive(0, 1, 1, 0, 1, 1, 16'h1111, 0, 0);
    step("z_w1", 1, 16'h1111, 16'h0, 0, 0, 5'd0);
    drive(0, 1, 1, 0, 0, 0, 16'h0, 1, 1);
    step("z_rsv1", 1, 16'h1111, 16'h0, 1, 0, 5'd1);

    // rd_en=0 holds A/B and busy outputs across address changes.
    drive(0, 0, 0, 1, 1, 2, 16'h2222, 0, 0);
    step("hold", 1, 16'h1111, 16'h0, 1, 0, 5'd1);
    drive(0, 0, 2, 2, 0, 0, 16'h0, 0, 0);
    step("hold2", 1, 16'h1111, 16'h0, 1, 0, 5'd1);
    drive(0, 1, 2, 1, 0, 0, 16'h0, 0, 0);
    step("z_rel", 1, 16'h2222, 16'h1111, 0, 1, 5'd1);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL leftover scoreboard entries observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
